// File: rtl/ex_mem_pkg.sv
// Shared defines for the EX/MEM pipeline register: bus widths, control levels,
// stall-vector bit positions and the per-cycle update mode decode.
package ex_mem_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned RegAddrBus   = 5;
    localparam int unsigned DoubleRegBus = 64;
    localparam int unsigned StallBus     = 6;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

    localparam int unsigned StallEx  = 3;
    localparam int unsigned StallMem = 4;

    typedef enum logic [1:0] {
        ModeNormal,
        ModeBubble,
        ModeHold,
        ModeFlush
    } mode_e;

    // Priority: flush > hold > bubble > normal. MEM stalled while EX runs
    // falls through to normal.
    function automatic mode_e decode_mode(logic [StallBus-1:0] stall, logic flush);
        if (flush) begin
            return ModeFlush;
        end else if (stall[StallEx] == Stop && stall[StallMem] == Stop) begin
            return ModeHold;
        end else if (stall[StallEx] == Stop) begin
            return ModeBubble;
        end else begin
            return ModeNormal;
        end
    endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with multi-cycle accumulator feedback to EX.
// Optional synchronous flush port enabled by defining EX_MEM_FLUSH_EN.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [StallBus-1:0]     stall,
`ifdef EX_MEM_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic [RegAddrBus-1:0]   ex_wd,
    input  logic                    ex_wreg,
    input  logic [RegBus-1:0]       ex_wdata,
    input  logic [RegBus-1:0]       ex_hi,
    input  logic [RegBus-1:0]       ex_lo,
    input  logic                    ex_whilo,
    input  logic [DoubleRegBus-1:0] hilo_i,
    input  logic [1:0]              cnt_i,
    output logic [RegAddrBus-1:0]   mem_wd,
    output logic                    mem_wreg,
    output logic [RegBus-1:0]       mem_wdata,
    output logic [RegBus-1:0]       mem_hi,
    output logic [RegBus-1:0]       mem_lo,
    output logic                    mem_whilo,
    output logic [DoubleRegBus-1:0] hilo_o,
    output logic [1:0]              cnt_o
);

    logic [RegAddrBus-1:0]   wd_q, wd_d;
    logic                    wreg_q, wreg_d;
    logic [RegBus-1:0]       wdata_q, wdata_d;
    logic [RegBus-1:0]       hi_q, hi_d;
    logic [RegBus-1:0]       lo_q, lo_d;
    logic                    whilo_q, whilo_d;
    logic [DoubleRegBus-1:0] hilo_q, hilo_d;
    logic [1:0]              cnt_q, cnt_d;
    mode_e                   mode;

`ifdef EX_MEM_FLUSH_EN
    assign mode = decode_mode(stall, flush);
`else
    assign mode = decode_mode(stall, 1'b0);
`endif

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        whilo_d = whilo_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        unique case (mode)
            ModeFlush: begin
                wd_d    = '0;
                wreg_d  = WriteDisable;
                wdata_d = ZeroWord;
                hi_d    = ZeroWord;
                lo_d    = ZeroWord;
                whilo_d = WriteDisable;
                hilo_d  = '0;
                cnt_d   = '0;
            end
            ModeHold: begin
                hilo_d = hilo_i;
                cnt_d  = cnt_i;
            end
            // Bubble must never carry a write enable into MEM.
            ModeBubble: begin
                wd_d    = '0;
                wreg_d  = WriteDisable;
                wdata_d = ZeroWord;
                hi_d    = ZeroWord;
                lo_d    = ZeroWord;
                whilo_d = WriteDisable;
                hilo_d  = hilo_i;
                cnt_d   = cnt_i;
            end
            ModeNormal: begin
                wd_d    = ex_wd;
                wreg_d  = ex_wreg;
                wdata_d = ex_wdata;
                hi_d    = ex_hi;
                lo_d    = ex_lo;
                whilo_d = ex_whilo;
                hilo_d  = '0;
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            wreg_q  <= WriteDisable;
            wdata_q <= ZeroWord;
            hi_q    <= ZeroWord;
            lo_q    <= ZeroWord;
            whilo_q <= WriteDisable;
            hilo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            whilo_q <= whilo_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wd    = wd_q;
    assign mem_wreg  = wreg_q;
    assign mem_wdata = wdata_q;
    assign mem_hi    = hi_q;
    assign mem_lo    = lo_q;
    assign mem_whilo = whilo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed vector table, hand-written reset and
// flush sequences, then randomized traffic against a behavioural model.
module tb_ex_mem;

    typedef struct packed {
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } in_t;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
`ifdef EX_MEM_FLUSH_EN
    logic        flush;
`endif

    int   n_cmp;
    int   n_err;
    out_t exp;
    out_t dut_out;
    vec_t vecs[9];

    ex_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
`ifdef EX_MEM_FLUSH_EN
        .flush     (flush),
`endif
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .ex_whilo  (ex_whilo),
        .hilo_i    (hilo_i),
        .cnt_i     (cnt_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .mem_whilo (mem_whilo),
        .hilo_o    (hilo_o),
        .cnt_o     (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb dut_out = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o};

    // MEM stalled while EX runs is an illegal stall combination.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
                else $error("illegal stall vector %b", stall);
        end
    end

    function automatic in_t mk_in(logic [5:0] s, logic [4:0] wd, logic wreg, logic [31:0] wdata,
                                  logic [31:0] hi, logic [31:0] lo, logic whilo,
                                  logic [63:0] hilo, logic [1:0] cnt);
        return '{stall:s, wd:wd, wreg:wreg, wdata:wdata, hi:hi, lo:lo, whilo:whilo,
                 hilo:hilo, cnt:cnt};
    endfunction

    function automatic out_t mk_out(logic [4:0] wd, logic wreg, logic [31:0] wdata,
                                    logic [31:0] hi, logic [31:0] lo, logic whilo,
                                    logic [63:0] hilo, logic [1:0] cnt);
        return '{wd:wd, wreg:wreg, wdata:wdata, hi:hi, lo:lo, whilo:whilo, hilo:hilo, cnt:cnt};
    endfunction

    // Reference: what the outputs become after one edge with inputs v.
    function automatic out_t model_next(out_t cur, in_t v, logic fl);
        out_t n;
        if (fl) begin
            n = '0;
        end else if (!v.stall[3]) begin
            n = mk_out(v.wd, v.wreg, v.wdata, v.hi, v.lo, v.whilo, 64'h0, 2'h0);
        end else begin
            n = v.stall[4] ? cur : '0;
            n.hilo = v.hilo;
            n.cnt  = v.cnt;
        end
        return n;
    endfunction

    task automatic drive(in_t v);
        stall    = v.stall;
        ex_wd    = v.wd;
        ex_wreg  = v.wreg;
        ex_wdata = v.wdata;
        ex_hi    = v.hi;
        ex_lo    = v.lo;
        ex_whilo = v.whilo;
        hilo_i   = v.hilo;
        cnt_i    = v.cnt;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic check_out(string tag, out_t e);
        check({tag, ".mem_wd"},    64'(dut_out.wd),    64'(e.wd));
        check({tag, ".mem_wreg"},  64'(dut_out.wreg),  64'(e.wreg));
        check({tag, ".mem_wdata"}, 64'(dut_out.wdata), 64'(e.wdata));
        check({tag, ".mem_hi"},    64'(dut_out.hi),    64'(e.hi));
        check({tag, ".mem_lo"},    64'(dut_out.lo),    64'(e.lo));
        check({tag, ".mem_whilo"}, 64'(dut_out.whilo), 64'(e.whilo));
        check({tag, ".hilo_o"},    dut_out.hilo,       e.hilo);
        check({tag, ".cnt_o"},     64'(dut_out.cnt),   64'(e.cnt));
    endtask

    task automatic step(in_t v, logic fl, string tag);
`ifdef EX_MEM_FLUSH_EN
        flush = fl;
`endif
        exp = model_next(exp, v, fl);
        drive(v);
        @(posedge clk);
        #1;
        check_out(tag, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
`ifdef EX_MEM_FLUSH_EN
        flush = 1'b0;
`endif
        drive('0);

        vecs[0] = '{in: mk_in(6'b000000, 5'd3, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0,
                              64'hDEAD, 2'd3),
                    exp: mk_out(5'd3, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0)};
        vecs[1] = '{in: mk_in(6'b001111, 5'd7, 1'b1, 32'hCAFE, 32'h5, 32'h6, 1'b1,
                              64'hFFFF_0000_0000_0001, 2'd1),
                    exp: mk_out(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                                64'hFFFF_0000_0000_0001, 2'd1)};
        vecs[2] = '{in: mk_in(6'b000000, 5'd7, 1'b1, 32'hCAFE, 32'h5, 32'h6, 1'b1,
                              64'h1234, 2'd2),
                    exp: mk_out(5'd7, 1'b1, 32'hCAFE, 32'h5, 32'h6, 1'b1, 64'h0, 2'd0)};
        vecs[3] = '{in: mk_in(6'b000000, 5'd0, 1'b0, 32'h0, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0),
                    exp: mk_out(5'd0, 1'b0, 32'h0, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0)};
        vecs[4] = '{in: mk_in(6'b000000, 5'd9, 1'b1, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0,
                              64'h0, 2'd0),
                    exp: mk_out(5'd9, 1'b1, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0)};
        vecs[5] = '{in: mk_in(6'b011111, 5'd10, 1'b0, 32'h1111_1111, 32'h3, 32'h4, 1'b1,
                              64'h55, 2'd1),
                    exp: mk_out(5'd9, 1'b1, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0, 64'h55, 2'd1)};
        vecs[6] = '{in: mk_in(6'b011111, 5'd10, 1'b0, 32'h2222_2222, 32'h3, 32'h4, 1'b1,
                              64'h66, 2'd2),
                    exp: mk_out(5'd9, 1'b1, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0, 64'h66, 2'd2)};
        vecs[7] = '{in: mk_in(6'b011111, 5'd10, 1'b0, 32'h3333_3333, 32'h3, 32'h4, 1'b1,
                              64'h77, 2'd3),
                    exp: mk_out(5'd9, 1'b1, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0, 64'h77, 2'd3)};
        // Bits outside 3/4 must be ignored.
        vecs[8] = '{in: mk_in(6'b100111, 5'd1, 1'b1, 32'h0F0F_0F0F, 32'h0, 32'h0, 1'b0,
                              64'h99, 2'd1),
                    exp: mk_out(5'd1, 1'b1, 32'h0F0F_0F0F, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0)};

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", '0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].in);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp);
        end
        exp = vecs[8].exp;

        // Async reset while mem_wreg=1 and cnt_o=2.
        step(mk_in(6'b000000, 5'd4, 1'b1, 32'h44, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0), 1'b0,
             "pre_rst_load");
        step(mk_in(6'b011111, 5'd5, 1'b0, 32'h55, 32'h0, 32'h0, 1'b0, 64'hABC, 2'd2), 1'b0,
             "pre_rst_hold");
        #3;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", '0);
        rst_n = 1'b1;
        #1;
        check_out("rst_release", '0);
        exp = '0;
        step(mk_in(6'b001111, 5'd6, 1'b1, 32'h66, 32'h0, 32'h0, 1'b1, 64'h42, 2'd1), 1'b0,
             "first_after_rst");

`ifdef EX_MEM_FLUSH_EN
        step(mk_in(6'b000000, 5'd8, 1'b1, 32'h88, 32'h8, 32'h9, 1'b1, 64'h0, 2'd0), 1'b0,
             "pre_flush_load");
        step(mk_in(6'b011111, 5'd8, 1'b1, 32'h88, 32'h8, 32'h9, 1'b1, 64'h123, 2'd3), 1'b0,
             "pre_flush_hold");
        step(mk_in(6'b011111, 5'd8, 1'b1, 32'h88, 32'h8, 32'h9, 1'b1, 64'h456, 2'd2), 1'b1,
             "flush");
`endif

        for (int i = 0; i < 400; i++) begin
            in_t r;
            logic fl;
            int  m;
            r.stall = 6'($urandom);
            m = int'($urandom_range(0, 2));
            r.stall[3] = (m != 0);
            r.stall[4] = (m == 2);
            r.wd    = 5'($urandom);
            r.wreg  = 1'($urandom);
            r.wdata = $urandom;
            r.hi    = $urandom;
            r.lo    = $urandom;
            r.whilo = 1'($urandom);
            r.hilo  = {$urandom, $urandom};
            r.cnt   = 2'($urandom);
            fl = 1'b0;
`ifdef EX_MEM_FLUSH_EN
            fl = ($urandom_range(0, 15) == 0);
`endif
            step(r, fl, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
